alu_result_display: RTL
=======================

Name: alu_result_display

Overview:
- Downstream consumer of the 3-bit-operand ALU. Captures the ALU's 6-bit result f and the selected opcode, then converts the result to two BCD digits using a sequential shift-add-3 FSM.
- Drives a 4-digit multiplexed, active-low 7-segment display on the lab board.
- Digit 3 shows the opcode (0-7), digit 2 is blank (or a sign), and digits 1-0 show the result in decimal (0-63).

Parameters:
- REFRESH_DIV, 50000, clk cycles each digit stays lit before the scan advances; must be >= 2.
- BLANK_LEAD, 1, 1 = blank the tens digit when it is 0; 0 = always show it.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  synchronous, active-low reset.
- load  in  1  single-cycle capture strobe, already synchronous to clk.
- f  in  6  ALU result.
- opcode  in  3  ALU opcodesel.
- an  out  4  digit anodes, active-low, one-hot-low while scanning.
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low; held 1 (off).
- busy  out  1  high while a conversion is in progress.

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low. All state updates on posedge clk only.
- Reset (rst_n=0 at a clock edge):
  - an=4'b1111, seg=7'b1111111, dp=1, busy=0.
  - FSM=IDLE, refresh counter=0, digit index=0.
  - All four display digit registers = BLANK.
  - Reset mid-conversion aborts it; the display stays blank.
- FSM states: IDLE -> SHIFT -> DONE -> IDLE.
  - IDLE: when load=1, latch f into a shift register, latch opcode, clear the BCD accumulator, and set the iteration count to 0. Next state SHIFT; busy=1 from the next cycle.
  - SHIFT: each cycle, add 3 to any BCD nibble >= 5, then shift {bcd,bin} left by 1. Exactly 6 iterations, then go to DONE.
  - DONE: commit tens, units and opcode to the display digit registers; busy=0 next cycle; return to IDLE.
  - Latency: load sampled at edge N. busy=1 for edges N+1..N+7. New digits are visible from edge N+8.
- Arithmetic: the result range is 0..63, so tens is 0..6. The BCD accumulator is 8 bits.
- Digit registers:
  - d3 = opcode digit.
  - d2 = BLANK.
  - d1 = tens, or BLANK when tens==0 and BLANK_LEAD=1.
  - d0 = units.
- load while busy=1 is ignored (not queued). The captured f/opcode are never changed mid-conversion.
- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1. On wrap, the digit index increments 0->1->2->3->0.
  - an = ~(1<<index). The first cycle out of reset drives an=4'b1110.
  - seg is registered together with an, so they are glitch-free and change on the same edge.
  - Scanning continues during conversion; the old digits are shown until DONE.
- Segment codes (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - BLANK=1111111, MINUS=0111111

Optional Feature:
- Macro: SIGNED_SUB_DISPLAY_EN.
- Defined: when the latched opcode==3'b010 (SUB) and f[5]==1, convert the magnitude (~f+1) & 6'h3F instead of f, and set d2=MINUS. Example: f=6'h3F displays "2 -01" (or "2 - 1" with BLANK_LEAD=1).
- Defined, all other cases: d2=BLANK.
- Not defined: f is always treated as unsigned 0..63 and d2 is always BLANK. No magnitude logic is synthesized.

Test Plan:
- Reset behaviour: hold rst_n=0 for 3 cycles, then release -> an=1111 and seg=1111111 during reset; an=1110 and seg=BLANK on the first cycle after release; busy=0.
- Basic conversion (REFRESH_DIV=4): load with f=6'd42, opcode=3'd3 -> busy high for exactly 7 cycles. Scanning digits 0..3 then shows seg 0100100 ("2"), 0011001 ("4"), BLANK, 0110000 ("3").
- Boundaries and leading-zero blanking: f=0 -> d0 = "0", d1 = BLANK. f=63 -> "3","6". f=9 with BLANK_LEAD=0 -> d1 = "0".
- Load during busy: a second load with f=6'd7, two cycles after the first load (f=6'd20) -> ignored; the display shows 20 and busy deasserts at the original time.
- Reset mid-conversion: assert rst_n=0 during SHIFT iteration 3 -> the next edge gives busy=0 and all digits blank. A subsequent load with f=6'd15 converts correctly.
- Signed SUB: with SIGNED_SUB_DISPLAY_EN, opcode=2 and f=6'h3E -> d2=MINUS, value 2. Without the macro -> value 62 and d2=BLANK.

Source files
------------

// File: rtl/alu_result_display.sv
// Captures an ALU result/opcode, converts the result to BCD with a shift-add-3 FSM,
// and scans it onto a 4-digit active-low 7-segment display. Option: SIGNED_SUB_DISPLAY_EN.
module alu_result_display #(
  parameter int REFRESH_DIV = 50000,
  parameter bit BLANK_LEAD  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [5:0] f,
  input  logic [2:0] opcode,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       busy
);

  localparam int DATA_W = 6;
  localparam int CNT_W  = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [3:0] DIG_MINUS = 4'hE;
  localparam logic [3:0] DIG_BLANK = 4'hF;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t state, state_nxt;
  logic              cap_en, shift_en, commit_en;
  logic [2:0]        iter;
  logic [DATA_W-1:0] cap_bin;
  logic [DATA_W-1:0] bin_p0;
  logic [7:0]        bcd_p0;
  logic [2:0]        op_p0;
  logic [3:0]        dig [4];
  logic [CNT_W-1:0]  refresh_cnt;
  logic [1:0]        idx;
  logic [3:0]        an_p1;
  logic [6:0]        seg_p1;

  // One double-dabble iteration: correct each nibble >= 5, then shift {bcd,bin} left.
  function automatic logic [13:0] dabble_step(input logic [7:0] bcd, input logic [5:0] bin);
    logic [7:0] adj;
    adj[3:0] = (bcd[3:0] >= 4'd5) ? bcd[3:0] + 4'd3 : bcd[3:0];
    adj[7:4] = (bcd[7:4] >= 4'd5) ? bcd[7:4] + 4'd3 : bcd[7:4];
    return {adj[6:0], bin, 1'b0};
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:      return 7'b1000000;
      4'd1:      return 7'b1111001;
      4'd2:      return 7'b0100100;
      4'd3:      return 7'b0110000;
      4'd4:      return 7'b0011001;
      4'd5:      return 7'b0010010;
      4'd6:      return 7'b0000010;
      4'd7:      return 7'b1111000;
      4'd8:      return 7'b0000000;
      4'd9:      return 7'b0010000;
      DIG_MINUS: return 7'b0111111;
      default:   return 7'b1111111;
    endcase
  endfunction

`ifdef SIGNED_SUB_DISPLAY_EN
  logic cap_neg, neg_p0;
  assign cap_neg = (opcode == 3'b010) && f[5];
  assign cap_bin = cap_neg ? (~f + 6'd1) : f;
`else
  assign cap_bin = f;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cap_en    = 1'b0;
    shift_en  = 1'b0;
    commit_en = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          cap_en    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (iter == 3'd5) state_nxt = DONE;
      end
      DONE: begin
        commit_en = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)        iter <= 3'd0;
    else if (cap_en)   iter <= 3'd0;
    else if (shift_en) iter <= iter + 3'd1;
  end

  // Stage p0: capture and iterative BCD conversion
  always_ff @(posedge clk) begin
    if (cap_en) begin
      bin_p0 <= cap_bin;
      bcd_p0 <= 8'd0;
      op_p0  <= opcode;
`ifdef SIGNED_SUB_DISPLAY_EN
      neg_p0 <= cap_neg;
`endif
    end else if (shift_en) begin
      {bcd_p0, bin_p0} <= dabble_step(bcd_p0, bin_p0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) dig[i] <= DIG_BLANK;
    end else if (commit_en) begin
      dig[3] <= {1'b0, op_p0};
`ifdef SIGNED_SUB_DISPLAY_EN
      dig[2] <= neg_p0 ? DIG_MINUS : DIG_BLANK;
`else
      dig[2] <= DIG_BLANK;
`endif
      dig[1] <= (BLANK_LEAD && (bcd_p0[7:4] == 4'd0)) ? DIG_BLANK : bcd_p0[7:4];
      dig[0] <= bcd_p0[3:0];
    end
  end

  // Stage p1: scan counter and registered anode/cathode drive
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
      idx         <= 2'd0;
      an_p1       <= 4'b1111;
      seg_p1      <= 7'b1111111;
    end else begin
      an_p1  <= ~(4'b0001 << idx);
      seg_p1 <= seg_decode(dig[idx]);
      if (refresh_cnt == CNT_MAX) begin
        refresh_cnt <= '0;
        idx         <= idx + 2'd1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
    end
  end

  assign an   = an_p1;
  assign seg  = seg_p1;
  assign dp   = 1'b1;
  assign busy = (state != IDLE);

endmodule
